// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   req_valid     per-producer valid
//   req_data      packed producer data, producer i in [i*DATA_W +: DATA_W]
//   req_last      per-producer last-beat marker
//   req_ready     per-producer beat-accept strobe
//   fifo_full     FIFO full flag; stalls the current grant
//   write_enable  FIFO write strobe
//   data_in       FIFO write data, zero when not writing
//   grant_id      current or most recent grantee
//   busy          high while a grant is held
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        write_enable,
    output logic [DATA_W-1:0]           data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [GW-1:0]   rr_ptr_q, grant_id_q, pick_d, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q;
    logic            accept, release_g;
    logic [DATA_W-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        int j;
        j      = 0;
        pick_d = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[GW'(j)]) pick_d = GW'(j);
        end
    end

    assign busy         = (state_q == GRANT);
    assign grant_id     = grant_id_q;
    assign accept       = busy && req_valid[grant_id_q] && !fifo_full;
    assign write_enable = accept;
    assign data_in      = accept ? slice[grant_id_q] : '0;
    assign req_ready    = (busy && !fifo_full) ? (NUM_REQ'(1) << grant_id_q) : '0;
    // A full FIFO only stalls; a dropped valid ends the grant without a beat
    assign release_g    = busy && (!req_valid[grant_id_q] ||
                          (accept && (req_last[grant_id_q] || beat_cnt_q == CW'(MAX_BURST - 1))));
    assign rr_ptr_d     = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else if (!busy) begin
            if (|req_valid) begin
                state_q    <= GRANT;
                grant_id_q <= pick_d;
                beat_cnt_q <= '0;
            end
        end else begin
            if (accept) beat_cnt_q <= beat_cnt_q + 1'b1;
            if (release_g) begin
                state_q  <= IDLE;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares a single FIFO write port between NUM_REQ independent producers. Each producer offers data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats, then drives the FIFO's write_enable and data_in directly. It sits between the producer blocks and the FIFO instance and never writes while the FIFO reports full.

## Interface
Parameters:
- NUM_REQ, 4, number of producers; legal range 2..16.
- DATA_W, 8, data width; must match the FIFO width.
- MAX_BURST, 4, maximum beats per grant; legal range 2..256.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-producer data valid.
- req_data  input  NUM_REQ*DATA_W  producer i's data in bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks the final beat of producer i's burst.
- req_ready  output  NUM_REQ  beat accepted from producer i when req_valid[i] and req_ready[i] are both high.
- fifo_full  input  1  FIFO full flag.
- write_enable  output  1  FIFO write strobe.
- data_in  output  DATA_W  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grantee.
- busy  output  1  high while in GRANT.

## Operation
- Internal state:
  - 2-state FSM, IDLE and GRANT.
  - rr_ptr, $clog2(NUM_REQ) bits: highest-priority index for the next arbitration.
  - beat_cnt, $clog2(MAX_BURST) bits.
- IDLE:
  - If any req_valid is high, select the first set bit scanning upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Register the selection into grant_id, clear beat_cnt, go to GRANT.
  - All req_ready and write_enable are low in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full. Every other req_ready bit is 0.
  - write_enable = req_valid[g] & !fifo_full.
  - data_in = req_data slice g while write_enable is high, otherwise 0.
- On each accepted beat:
  - Increment beat_cnt.
  - Release the grant if req_last[g] is high or beat_cnt == MAX_BURST-1.
- The grant is also released if req_valid[g] is low, with no beat accepted that cycle.
- Release:
  - rr_ptr <= (g+1) mod NUM_REQ, FSM goes to IDLE.
  - grant_id holds its value in IDLE.
- fifo_full high in GRANT: stall only.
  - No beat is accepted and beat_cnt holds.
  - The grant is kept even if it exceeds MAX_BURST cycles.
  - The grant is not released while req_valid[g] stays high.
- Non-grantee valid bits are ignored while in GRANT.
- Requesters must hold req_data and req_last stable while valid is high and ready is low.
- Reset (asynchronous): FSM = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0.
  - While reset is asserted and after it releases: busy = 0, write_enable = 0, data_in = 0, req_ready = 0.
  - Reset mid-burst abandons the burst. Beats already written stay in the FIFO.

## Timing
- Arbitration latency:
  - req_valid rises in cycle N (IDLE), grant is registered at edge N+1, and the first beat is written in cycle N+1.
  - This gives one bubble cycle per grant.
- Throughput within a grant is one beat per cycle while fifo_full is low.
- A full grant of B beats occupies B+1 cycles including the IDLE cycle.
- req_ready and write_enable are combinational from the registered grant, req_valid and fifo_full. There is no combinational path from req_valid of one producer to req_ready of another.
- The FIFO samples write_enable and data_in at the same edge on which the producer sees its beat accepted.

## Test plan
- Reset:
  - Drive req_valid = 4'b1111 and pulse rst for 2 cycles asynchronously, mid-cycle.
  - Required: write_enable, busy and req_ready go to 0 immediately and stay 0 while rst is high.
  - Required: after release, the first grant goes to producer 0.
- Single producer:
  - Producer 2 sends 3 beats 0xA1, 0xA2, 0xA3 with last on 0xA3, fifo_full = 0.
  - Required: busy rises one cycle after valid, then 3 consecutive writes of 0xA1, 0xA2, 0xA3.
  - Required: the next cycle is IDLE with rr_ptr = 3.
- Burst cap:
  - Producer 0 sends 6 beats 0x10..0x15 with no last.
  - Required: 4 writes 0x10..0x13, release, one IDLE cycle, re-grant to 0, then writes 0x14 and 0x15 (others idle).
- Round-robin fairness:
  - All 4 producers hold valid, each sending single-beat bursts of value 0x40+i with last = 1.
  - Required: grant order 0, 1, 2, 3, 0, with write data 0x40, 0x41, 0x42, 0x43, 0x40 on alternate cycles.
- Full stall:
  - Producer 1 is mid-burst and fifo_full goes high for 3 cycles.
  - Required: write_enable = 0 and req_ready[1] = 0 for those 3 cycles, and grant_id stays 1.
  - Required: the burst resumes with the next beat on the cycle full drops, with no beat lost or duplicated.
- Valid drop:
  - The grantee deasserts valid after 1 of 4 beats.
  - Required: the grant is released in that cycle and the next-priority requester is granted one cycle later.
